// File: rtl/sharpen_cross_pipe.sv
// -----------------------------------------------------------------------------
// sharpen_cross_pipe
//   Two-stage AXI-Stream pipeline that sharpens a colour pixel using a
//   5-point cross Laplacian computed on an intensity neighbourhood.
//
//   S1: lap = 4*centre - up - down - left - right (signed, PXL_D_WIDTH+3 bits)
//   S2: per-channel result selected by the frame mode:
//         0 bypass    : original channel sample
//         1 sharpen   : clamp(org + ((lap*gain) >>> SHIFT), 0, max)
//         2 edge      : min(|lap|, max) on every channel
//         3 intensity : centre intensity on every channel
//   Mode and gain are captured on each tuser beat (and on the first beat
//   after reset) and apply to that beat and all later beats of the frame.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   din0..din4          centre, up, down, left, right intensity
//   in_org_pixels       original colour pixel aligned with din0 (ch0 in LSBs)
//   s_axis_*            input stream handshake and sideband
//   m_axis_*            output stream (tdata = processed colour pixel)
//   mode, gain          processing controls, sampled per frame
//   sat_count           (SHARPEN_SATCNT_EN only) clamped samples this frame
//
// Build option
//   SHARPEN_SATCNT_EN   adds the sat_count output and its counter.
// -----------------------------------------------------------------------------
module sharpen_cross_pipe #(
  parameter int PXL_D_WIDTH = 8,
  parameter int NUM_CH      = 3,
  parameter int GAIN_W      = 4,
  parameter int SHIFT       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PXL_D_WIDTH-1:0]          din0,
  input  logic [PXL_D_WIDTH-1:0]          din1,
  input  logic [PXL_D_WIDTH-1:0]          din2,
  input  logic [PXL_D_WIDTH-1:0]          din3,
  input  logic [PXL_D_WIDTH-1:0]          din4,
  input  logic [PXL_D_WIDTH*NUM_CH-1:0]   in_org_pixels,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tuser,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [PXL_D_WIDTH*NUM_CH-1:0]   m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic [1:0]                      mode,
  input  logic [GAIN_W-1:0]               gain
`ifdef SHARPEN_SATCNT_EN
  ,
  output logic [15:0]                     sat_count
`endif
);

  localparam int DATA_W = PXL_D_WIDTH * NUM_CH;
  localparam int LAP_W  = PXL_D_WIDTH + 3;
  localparam int PROD_W = LAP_W + GAIN_W + 1;  // gain is zero-extended to a signed operand
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [PXL_D_WIDTH-1:0]  PXL_MAX = '1;
  localparam logic [LAP_W-1:0]        ABS_MAX = LAP_W'(PXL_MAX);
  localparam logic signed [SUM_W-1:0] SUM_MAX = $signed(SUM_W'(PXL_MAX));

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_SHARPEN   = 2'd1,
    MODE_EDGE      = 2'd2,
    MODE_INTENSITY = 2'd3
  } mode_t;

  // Frame control registers
  mode_t                    r_frame_mode;
  logic [GAIN_W-1:0]        r_frame_gain;
  logic                     r_first;        // no beat accepted since reset

  // Stage 1
  logic                     r_s1_valid;
  logic                     r_s1_user;
  logic                     r_s1_last;
  logic signed [LAP_W-1:0]  r_s1_lap;
  logic [DATA_W-1:0]        r_s1_org;
  logic [PXL_D_WIDTH-1:0]   r_s1_din0;
  mode_t                    r_s1_mode;
  logic [GAIN_W-1:0]        r_s1_gain;

  // Stage 2
  logic                     r_s2_valid;
  logic                     r_s2_user;
  logic                     r_s2_last;
  logic [DATA_W-1:0]        r_s2_data;

  logic                     w_accept;
  logic                     w_latch;
  logic                     w_s1_adv;
  logic                     w_drain;
  mode_t                    w_mode;
  logic [GAIN_W-1:0]        w_gain;
  logic signed [LAP_W-1:0]  w_lap;
  logic [LAP_W-1:0]         w_abs_lap;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_delta;
  logic [DATA_W-1:0]        w_s2_data;

  // Handshake. The ready term is forced low while reset is asserted.
  assign s_axis_tready = !rst && (!r_s1_valid || !r_s2_valid || m_axis_tready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_s1_adv      = r_s1_valid && (!r_s2_valid || m_axis_tready);
  assign w_drain       = r_s2_valid && m_axis_tready;

  // A tuser beat (or the first beat after reset) takes the live controls and
  // also uses them itself; every other beat uses the frame registers.
  assign w_latch = w_accept && (s_axis_tuser || r_first);
  assign w_mode  = w_latch ? mode_t'(mode) : r_frame_mode;
  assign w_gain  = w_latch ? gain : r_frame_gain;

  // Range is [-4*max, 4*max], which fits in PXL_D_WIDTH+3 signed bits.
  assign w_lap = $signed({1'b0, din0, 2'b00})
               - $signed({3'b000, din1}) - $signed({3'b000, din2})
               - $signed({3'b000, din3}) - $signed({3'b000, din4});

  assign w_abs_lap = r_s1_lap[LAP_W-1] ? $unsigned(-r_s1_lap) : $unsigned(r_s1_lap);
  assign w_prod    = PROD_W'(r_s1_lap) * PROD_W'($signed({1'b0, r_s1_gain}));
  assign w_delta   = w_prod >>> SHIFT;

`ifdef SHARPEN_SATCNT_EN
  localparam int CNT_W = $clog2(NUM_CH + 1);
  logic [CNT_W-1:0] w_clamp_cnt;
  logic [CNT_W-1:0] r_s2_clamps;
  logic [15:0]      r_sat_cnt;
  logic [16:0]      w_cnt_sum;
`endif

  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [PXL_D_WIDTH-1:0]  w_org_c;
    logic signed [SUM_W-1:0] w_sum;
    w_s2_data = '0;
`ifdef SHARPEN_SATCNT_EN
    w_clamp_cnt = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      w_org_c = r_s1_org[c*PXL_D_WIDTH +: PXL_D_WIDTH];
      w_sum   = $signed(SUM_W'(w_org_c)) + SUM_W'(w_delta);
      w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = w_org_c;
      case (r_s1_mode)
        MODE_SHARPEN: begin
          if (w_sum[SUM_W-1]) begin
            w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = '0;
`ifdef SHARPEN_SATCNT_EN
            w_clamp_cnt = w_clamp_cnt + CNT_W'(1);
`endif
          end else if (w_sum > SUM_MAX) begin
            w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = PXL_MAX;
`ifdef SHARPEN_SATCNT_EN
            w_clamp_cnt = w_clamp_cnt + CNT_W'(1);
`endif
          end else begin
            w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = w_sum[PXL_D_WIDTH-1:0];
          end
        end
        MODE_EDGE: begin
          if (w_abs_lap > ABS_MAX) begin
            w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = PXL_MAX;
`ifdef SHARPEN_SATCNT_EN
            w_clamp_cnt = w_clamp_cnt + CNT_W'(1);
`endif
          end else begin
            w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = w_abs_lap[PXL_D_WIDTH-1:0];
          end
        end
        MODE_INTENSITY: w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = r_s1_din0;
        default:        w_s2_data[c*PXL_D_WIDTH +: PXL_D_WIDTH] = w_org_c;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the datapath registers are reset along with the valid flags so the
  // output bus reads zero during and right after reset, not stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_mode <= MODE_BYPASS;
      r_frame_gain <= '0;
      r_first      <= 1'b1;
      r_s1_valid   <= 1'b0;
      r_s1_user    <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_lap     <= '0;
      r_s1_org     <= '0;
      r_s1_din0    <= '0;
      r_s1_mode    <= MODE_BYPASS;
      r_s1_gain    <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_user    <= 1'b0;
      r_s2_last    <= 1'b0;
      r_s2_data    <= '0;
    end else begin
      if (w_accept) r_first <= 1'b0;
      if (w_latch) begin
        r_frame_mode <= mode_t'(mode);
        r_frame_gain <= gain;
      end

      if (w_accept)      r_s1_valid <= 1'b1;
      else if (w_s1_adv) r_s1_valid <= 1'b0;
      if (w_accept) begin
        r_s1_user <= s_axis_tuser;
        r_s1_last <= s_axis_tlast;
        r_s1_lap  <= w_lap;
        r_s1_org  <= in_org_pixels;
        r_s1_din0 <= din0;
        r_s1_mode <= w_mode;
        r_s1_gain <= w_gain;
      end

      // S2 only loads on advance, so a stalled output beat stays put.
      if (w_s1_adv)     r_s2_valid <= 1'b1;
      else if (w_drain) r_s2_valid <= 1'b0;
      if (w_s1_adv) begin
        r_s2_user <= r_s1_user;
        r_s2_last <= r_s1_last;
        r_s2_data <= w_s2_data;
      end
    end
  end

  assign m_axis_tvalid = r_s2_valid;
  assign m_axis_tuser  = r_s2_user;
  assign m_axis_tlast  = r_s2_last;
  assign m_axis_tdata  = r_s2_data;

`ifdef SHARPEN_SATCNT_EN
  // Counter is updated as each beat leaves S2; a departing tuser beat starts
  // the new frame's count with its own clamps.
  assign w_cnt_sum = {1'b0, r_sat_cnt} + 17'(r_s2_clamps);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_clamps <= '0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_s1_adv) r_s2_clamps <= w_clamp_cnt;
      if (w_drain) begin
        if (r_s2_user)         r_sat_cnt <= 16'(r_s2_clamps);
        else if (w_cnt_sum[16]) r_sat_cnt <= 16'hFFFF;
        else                   r_sat_cnt <= w_cnt_sum[15:0];
      end
    end
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_sharpen_cross_pipe.sv
// -----------------------------------------------------------------------------
// tb_sharpen_cross_pipe
//   Directed bench for sharpen_cross_pipe (PXL_D_WIDTH=8, NUM_CH=3, GAIN_W=4,
//   SHIFT=2). A reference model computes every expected output beat from the
//   accepted inputs with plain integer arithmetic; a monitor compares each
//   output transfer against it and checks that stalled outputs hold. Directed
//   sequences also pin hand-computed literal results.
//   Define SHARPEN_SATCNT_EN to also check the saturation counter.
// -----------------------------------------------------------------------------
module tb_sharpen_cross_pipe;

  localparam int PW = 8;
  localparam int NC = 3;
  localparam int DW = PW * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] din0, din1, din2, din3, din4;
  logic [DW-1:0] org;
  logic          s_tvalid, s_tuser, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, m_tready;
  logic [1:0]    mode;
  logic [3:0]    gain;
`ifdef SHARPEN_SATCNT_EN
  logic [15:0]   sat_count;
`endif

  always #5 clk = ~clk;

  sharpen_cross_pipe #(
    .PXL_D_WIDTH(PW), .NUM_CH(NC), .GAIN_W(4), .SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3), .din4(din4),
    .in_org_pixels(org),
    .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .mode(mode), .gain(gain)
`ifdef SHARPEN_SATCNT_EN
    , .sat_count(sat_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
    int            clamps;
  } beat_t;

  beat_t         exp_q[$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            n_out   = 0;
  logic [DW-1:0] last_out = '0;
  int            bm_mode, bm_gain, bm_cnt;
  logic          bm_first;
  logic          prev_stall;
  logic [DW+1:0] prev_bus;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected output from the block's arithmetic rules.
  function automatic beat_t model_beat(input int d0, d1, d2, d3, d4,
                                       input logic [DW-1:0] o, input int md, gn,
                                       input logic u, l);
    beat_t b;
    int lap, mag, delta, sum, oc, v;
    lap   = 4*d0 - d1 - d2 - d3 - d4;
    mag   = (lap < 0) ? -lap : lap;
    delta = (lap * gn) >>> 2;
    b.clamps = 0;
    b.data   = '0;
    for (int c = 0; c < NC; c++) begin
      oc = int'(o[c*PW +: PW]);
      case (md)
        1: begin
          sum = oc + delta;
          if (sum < 0)        begin v = 0;   b.clamps++; end
          else if (sum > 255) begin v = 255; b.clamps++; end
          else                v = sum;
        end
        2: if (mag > 255) begin v = 255; b.clamps++; end else v = mag;
        3: v = d0;
        default: v = oc;
      endcase
      b.data[c*PW +: PW] = 8'(v);
    end
    b.user = u;
    b.last = l;
    return b;
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      bm_first   = 1'b1;
      bm_mode    = 0;
      bm_gain    = 0;
      bm_cnt     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_bus", {m_tuser, m_tlast, m_tdata}, prev_bus);
      end
`ifdef SHARPEN_SATCNT_EN
      check("sat_count_track", sat_count, bm_cnt);
`endif
      if (m_tvalid && m_tready) begin
        check("out_unexpected", exp_q.size() == 0, 0);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_user", m_tuser, e.user);
          check("out_last", m_tlast, e.last);
          last_out = m_tdata;
          n_out++;
          if (e.user)                       bm_cnt = e.clamps;
          else if (bm_cnt + e.clamps > 65535) bm_cnt = 65535;
          else                              bm_cnt = bm_cnt + e.clamps;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_bus   = {m_tuser, m_tlast, m_tdata};
      if (s_tvalid && s_tready) begin
        if (s_tuser || bm_first) begin
          bm_mode  = int'(mode);
          bm_gain  = int'(gain);
          bm_first = 1'b0;
        end
        exp_q.push_back(model_beat(din0, din1, din2, din3, din4, org,
                                   bm_mode, bm_gain, s_tuser, s_tlast));
      end
    end
  end

  // Drive one beat and return just after the edge that accepts it.
  task automatic send(input int d0, d1, d2, d3, d4, input logic [DW-1:0] o,
                      input logic [1:0] md, input logic [3:0] gn, input logic u, l);
    int w;
    din0 = 8'(d0); din1 = 8'(d1); din2 = 8'(d2); din3 = 8'(d3); din4 = 8'(d4);
    org = o; mode = md; gain = gn; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (s_tready || w >= 100) break;
      w++;
    end
    check("send_ready", s_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < budget) begin
      @(negedge clk); #1;
      w++;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0; din4 = '0;
    org = '0; mode = '0; gain = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_tready", s_tready, 0);
`ifdef SHARPEN_SATCNT_EN
    check("rst_sat_count", sat_count, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Sharpen: lap = 40, delta = 40*4>>2 = 40, 100+40 = 140; two-cycle latency.
    send(100, 90, 90, 90, 90, 24'h646464, 2'd1, 4'd4, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_not_yet", m_tvalid, 0);
    @(negedge clk);
    check("lat_valid", m_tvalid, 1);
    check("sharpen_140", m_tdata, 24'h8C8C8C);
    @(posedge clk); #1;

    // Clamp high then low, same frame.
    send(255, 0, 0, 0, 0, {8'd0, 8'd10, 8'd200}, 2'd1, 4'd4, 1'b0, 1'b0);
    wait_drain(20);
    check("clamp_high", last_out, 24'hFFFFFF);
    send(0, 255, 255, 255, 255, {8'd0, 8'd10, 8'd200}, 2'd1, 4'd4, 1'b0, 1'b1);
    wait_drain(20);
    check("clamp_low", last_out, 24'h000000);
`ifdef SHARPEN_SATCNT_EN
    check("sat_count_6", sat_count, 6);
`endif

    // Bypass and intensity.
    send(10, 20, 30, 40, 50, 24'h123456, 2'd0, 4'd7, 1'b1, 1'b0);
    wait_drain(20);
    check("bypass", last_out, 24'h123456);
    send(77, 10, 10, 10, 10, 24'hABCDEF, 2'd3, 4'd7, 1'b1, 1'b1);
    wait_drain(20);
    check("intensity_77", last_out, 24'h4D4D4D);

    // Frame lock: a mode change without tuser is ignored until the next tuser.
    send(100, 90, 90, 90, 90, 24'h646464, 2'd1, 4'd4, 1'b1, 1'b0);
    wait_drain(20);
    check("lock_sharpen", last_out, 24'h8C8C8C);
    send(100, 90, 90, 90, 90, 24'h646464, 2'd2, 4'd4, 1'b0, 1'b1);
    wait_drain(20);
    check("lock_held", last_out, 24'h8C8C8C);
    send(100, 90, 90, 90, 90, 24'h646464, 2'd2, 4'd4, 1'b1, 1'b1);
    wait_drain(20);
    check("lock_edge_40", last_out, 24'h282828);

    // Backpressure: 8-beat stream, output stalled for 5 cycles.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(50 + 10*i, 40 + 20*(i%3), 45 + i, 30, 60 - i,
               {8'(i*20), 8'd128, 8'(255 - i*30)}, 2'd1, 4'(i + 2),
               (i == 0), (i == 7));
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        check("bp_s_tready_low", s_tready, 0);
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    wait_drain(50);
    check("bp_count", n_out - n0, 8);

    // Reset with both stages full.
    m_tready = 1'b0;
    send(120, 10, 20, 30, 40, 24'h0A0B0C, 2'd1, 4'd3, 1'b1, 1'b0);
    send(130, 15, 25, 35, 45, 24'h0D0E0F, 2'd1, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("full_s_tready", s_tready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_beat", m_tvalid, 0);

    // First beat after reset latches controls even without tuser.
    send(77, 1, 2, 3, 4, 24'h010203, 2'd3, 4'd0, 1'b0, 1'b1);
    wait_drain(20);
    check("post_rst_first", last_out, 24'h4D4D4D);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sharpen_cross_pipe.md
SHARPEN_CROSS_PIPE -- requirements
Module: sharpen_cross_pipe

Interface
REQ-001 SHALL have parameter PXL_D_WIDTH, default 8: bits per intensity/channel sample.
REQ-002 SHALL have parameter NUM_CH, default 3: colour channels in in_org_pixels/m_axis_tdata.
REQ-003 SHALL have parameter GAIN_W, default 4: width of gain input, unsigned.
REQ-004 SHALL have parameter SHIFT, default 2: arithmetic right shift applied after gain multiply.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: din0..din4  in  PXL_D_WIDTH each  centre, up, down, left, right intensity.
REQ-007 SHALL have ports: in_org_pixels  in  PXL_D_WIDTH*NUM_CH  original colour pixel aligned with din0.
REQ-008 SHALL have ports: s_axis_tvalid/tuser/tlast  in  1; s_axis_tready  out  1.
REQ-009 SHALL have ports: m_axis_tdata  out  PXL_D_WIDTH*NUM_CH; m_axis_tvalid/tuser/tlast  out  1; m_axis_tready  in  1.
REQ-010 SHALL have ports: mode  in  2  0 bypass, 1 sharpen, 2 edge, 3 intensity; gain  in  GAIN_W.

Function
REQ-011 SHALL be a 2-stage pipeline (S1, S2), each stage holding a valid flag plus data, tuser, tlast.
REQ-012 SHALL accept a beat when s_axis_tvalid && s_axis_tready; s_axis_tready = !S1.valid || !S2.valid || m_axis_tready.
REQ-013 SHALL advance S1->S2 when S1.valid && (!S2.valid || m_axis_tready); S2 drains on m_axis_tvalid && m_axis_tready.
REQ-014 SHALL present output 2 cycles after acceptance when m_axis_tready stays high; throughput 1 beat/cycle.
REQ-015 SHALL hold m_axis_* stable while m_axis_tvalid && !m_axis_tready; no beat lost or duplicated.
REQ-016 SHALL compute in S1: lap = 4*din0 - din1 - din2 - din3 - din4, signed, PXL_D_WIDTH+3 bits, no overflow.
REQ-017 SHALL compute in S2 per channel c: delta = (lap*gain) >>> SHIFT, signed; sum = org_c + delta at full width.
REQ-018 SHALL saturate sum to [0, 2^PXL_D_WIDTH-1] for mode 1.
REQ-019 SHALL output, mode 0: in_org_pixels unchanged; mode 2: min(|lap|, 2^PXL_D_WIDTH-1) on every channel; mode 3: din0 on every channel.
REQ-020 SHALL latch mode and gain into frame registers on an accepted beat with s_axis_tuser=1; that beat and all later beats use the latched values until the next tuser beat.
REQ-021 SHALL latch mode and gain on the first accepted beat after reset even if tuser=0.
REQ-022 SHALL carry tuser/tlast through both stages aligned with their data beat.
REQ-023 SHALL treat simultaneous S2 drain and S1 advance in one cycle as a legal transfer with no bubble.

Reset
REQ-024 SHALL, while rst=1, clear both valid flags, frame mode to 0, frame gain to 0, all data/sideband registers to 0.
REQ-025 SHALL drive m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, s_axis_tready=0 during reset.
REQ-026 SHALL discard in-flight beats on reset mid-frame; first post-reset beat is processed per REQ-021.

Configuration
REQ-027 SHALL, with macro SHARPEN_SATCNT_EN defined, add output sat_count (16 bits): counts channel samples clamped by REQ-018/REQ-019 per frame, cleared when a tuser beat leaves S2, saturating at 0xFFFF, reset to 0.
REQ-028 SHALL, without SHARPEN_SATCNT_EN, have no sat_count port and no counter logic; all other behaviour identical.

Verification (PXL_D_WIDTH=8, NUM_CH=3, SHIFT=2)
REQ-029 SHALL test sharpen: mode=1, gain=4, din0=100, din1..4=90, org=(100,100,100) -> out (140,140,140) 2 cycles later.
REQ-030 SHALL test clamp: mode=1, gain=4, din0=255, din1..4=0, org=(200,10,0) -> (255,255,255); din0=0, din1..4=255 -> (0,0,0); sat_count=6 if enabled.
REQ-031 SHALL test backpressure: stream 8 beats, m_axis_tready low cycles 3-7 -> s_axis_tready low after 2 beats buffered, all 8 outputs in order, data held stable.
REQ-032 SHALL test frame lock: mode changed 1->2 mid-frame -> output unchanged until next tuser beat, then edge output (lap=40 -> 40).
REQ-033 SHALL test reset mid-stream: rst pulsed with both stages full -> m_axis_tvalid=0 next cycle, no stale beat emitted afterwards.
REQ-034 SHALL test bypass/intensity: mode=0 -> org passthrough; mode=3, din0=77 -> (77,77,77).
